// File: rtl/ram_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ram_mmio                                                         |
// | Brief   : dual-port word RAM with byte-enable writes, keyboard register and |
// |           registered LCD shadow window                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_mmio #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int KBD_ADDR  = 25,
  parameter int LCD_BASE  = 42,
  parameter int LCD_WORDS = 8,
  parameter     INIT_FILE = "cpu.mem"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_instr_req,
  input  logic [ADDR_W-1:0]           i_instr_addr,
  output logic [DATA_W-1:0]           o_instr_rdata,
  output logic                        o_instr_ack,
  input  logic                        i_data_req,
  input  logic                        i_data_we,
  input  logic [DATA_W/8-1:0]         i_data_be,
  input  logic [ADDR_W-1:0]           i_data_addr,
  input  logic [DATA_W-1:0]           i_data_wdata,
  output logic [DATA_W-1:0]           o_data_rdata,
  output logic                        o_data_ack,
  output logic                        o_data_err,
  input  logic                        i_kbd_strobe,
  input  logic [15:0]                 i_keyboard_in,
  output logic [LCD_WORDS*DATA_W-1:0] o_lcd_data_out,
  output logic                        o_lcd_update
);

  localparam int                c_NB    = DATA_W / 8;
  localparam int                c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_KBD   = ADDR_W'(KBD_ADDR);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0]                r_instr_rdata;
  logic                             r_instr_ack;
  logic [DATA_W-1:0]                r_data_rdata;
  logic                             r_data_ack;
  logic                             r_data_err;
  logic [15:0]                      r_kbd_latch;
  logic                             r_kbd_pending;
  logic [LCD_WORDS-1:0][DATA_W-1:0] r_lcd;
  logic                             r_lcd_update;

  logic                             w_d_in;
  logic                             w_i_in;
  logic                             w_d_kbd;
  logic                             w_i_kbd;
  logic [c_IDX_W-1:0]               w_d_idx;
  logic [c_IDX_W-1:0]               w_i_idx;
  logic [DATA_W-1:0]                w_d_old;
  logic [DATA_W-1:0]                w_i_old;
  logic [DATA_W-1:0]                w_d_merged;
  logic                             w_d_wr;
  logic                             w_bypass;
  logic [DATA_W-1:0]                w_kbd_word;
  logic [DATA_W-1:0]                w_d_rd_val;
  logic [DATA_W-1:0]                w_i_rd_val;
  logic [LCD_WORDS-1:0]             w_lcd_hit;
  logic [LCD_WORDS-1:0][DATA_W-1:0] w_lcd_next;

  assign w_d_in   = ({1'b0, i_data_addr} < c_DEPTH);
  assign w_i_in   = ({1'b0, i_instr_addr} < c_DEPTH);
  assign w_d_kbd  = (i_data_addr == c_KBD);
  assign w_i_kbd  = (i_instr_addr == c_KBD);
  assign w_d_idx  = i_data_addr[c_IDX_W-1:0];
  assign w_i_idx  = i_instr_addr[c_IDX_W-1:0];
  assign w_d_old  = r_mem[w_d_idx];
  assign w_i_old  = r_mem[w_i_idx];
  assign w_d_wr   = i_data_req & i_data_we & w_d_in & ~w_d_kbd;
  assign w_bypass = w_d_wr & (i_instr_addr == i_data_addr);

  always_comb begin
    w_d_merged = w_d_old;
    for (int k = 0; k < c_NB; k++) begin
      if (i_data_be[k]) w_d_merged[8*k +: 8] = i_data_wdata[8*k +: 8];
    end
  end

  always_comb begin
    w_kbd_word           = '0;
    w_kbd_word[15:0]     = r_kbd_latch;
    w_kbd_word[DATA_W-1] = r_kbd_pending;
  end

  // Keyboard decode takes priority over the memory and the range check.
  always_comb begin
    w_d_rd_val = '0;
    w_i_rd_val = '0;
    if (w_d_kbd)     w_d_rd_val = w_kbd_word;
    else if (w_d_in) w_d_rd_val = w_d_old;
    if (w_i_kbd)       w_i_rd_val = w_kbd_word;
    else if (w_bypass) w_i_rd_val = w_d_merged;
    else if (w_i_in)   w_i_rd_val = w_i_old;
  end

  always_comb begin
    w_lcd_hit  = '0;
    w_lcd_next = r_lcd;
    for (int i = 0; i < LCD_WORDS; i++) begin
      if (w_d_wr && (i_data_addr == ADDR_W'(LCD_BASE + i))) begin
        w_lcd_hit[i] = 1'b1;
        for (int k = 0; k < c_NB; k++) begin
          if (i_data_be[k]) w_lcd_next[i][8*k +: 8] = i_data_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_d_wr) r_mem[w_d_idx] <= w_d_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_rdata <= '0;
      r_instr_ack   <= 1'b0;
      r_data_rdata  <= '0;
      r_data_ack    <= 1'b0;
      r_data_err    <= 1'b0;
      r_kbd_latch   <= '0;
      r_kbd_pending <= 1'b0;
      r_lcd         <= '0;
      r_lcd_update  <= 1'b0;
    end else begin
      r_instr_ack  <= i_instr_req;
      r_data_ack   <= i_data_req;
      r_data_err   <= i_data_req & ~w_d_in & ~w_d_kbd;
      r_lcd        <= w_lcd_next;
      r_lcd_update <= |w_lcd_hit;
      if (i_instr_req) r_instr_rdata <= w_i_rd_val;
      if (i_data_req)  r_data_rdata  <= w_d_rd_val;
      // A new key code wins over a clearing read on the same edge.
      if (i_kbd_strobe) begin
        r_kbd_latch   <= i_keyboard_in;
        r_kbd_pending <= 1'b1;
      end else if (i_data_req && !i_data_we && w_d_kbd) begin
        r_kbd_pending <= 1'b0;
      end
    end
  end

  assign o_instr_rdata  = r_instr_rdata;
  assign o_instr_ack    = r_instr_ack;
  assign o_data_rdata   = r_data_rdata;
  assign o_data_ack     = r_data_ack;
  assign o_data_err     = r_data_err;
  assign o_lcd_data_out = r_lcd;
  assign o_lcd_update   = r_lcd_update;

endmodule
`default_nettype wire

// File: tb/tb_ram_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ram_mmio                                                      |
// | Brief   : scoreboard bench for ram_mmio (DEPTH reduced to reach err path)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ram_mmio;

  localparam int c_DEPTH = 200;
  localparam int c_KBD   = 25;
  localparam int c_LCD   = 42;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_instr_req = 1'b0;
  logic [7:0]   i_instr_addr = '0;
  logic [31:0]  o_instr_rdata;
  logic         o_instr_ack;
  logic         i_data_req = 1'b0;
  logic         i_data_we = 1'b0;
  logic [3:0]   i_data_be = '0;
  logic [7:0]   i_data_addr = '0;
  logic [31:0]  i_data_wdata = '0;
  logic [31:0]  o_data_rdata;
  logic         o_data_ack;
  logic         o_data_err;
  logic         i_kbd_strobe = 1'b0;
  logic [15:0]  i_keyboard_in = '0;
  logic [255:0] o_lcd_data_out;
  logic         o_lcd_update;

  ram_mmio #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(c_DEPTH), .KBD_ADDR(c_KBD),
    .LCD_BASE(c_LCD), .LCD_WORDS(8), .INIT_FILE("")
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_rdata(o_instr_rdata), .o_instr_ack(o_instr_ack),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_be(i_data_be),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_rdata(o_data_rdata), .o_data_ack(o_data_ack), .o_data_err(o_data_err),
    .i_kbd_strobe(i_kbd_strobe), .i_keyboard_in(i_keyboard_in),
    .o_lcd_data_out(o_lcd_data_out), .o_lcd_update(o_lcd_update)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem [256];
  logic [31:0] m_lcd [8];
  logic [15:0] m_latch;
  logic        m_pend;
  logic [31:0] iq [$];
  exp_t        dq [$];
  logic        r_sent_i, r_sent_d;
  logic [7:0]  a1, a2;
  logic [255:0] lcd_mask;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] kbd_word();
    return {m_pend, 15'b0, m_latch};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent_i <= 1'b0;
      r_sent_d <= 1'b0;
    end else begin
      r_sent_i <= i_instr_req;
      r_sent_d <= i_data_req;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] ei;
    check_eq("iack", o_instr_ack, r_sent_i);
    check_eq("dack", o_data_ack, r_sent_d);
    if (o_instr_ack && iq.size() > 0) begin
      ei = iq.pop_front();
      if (!$isunknown(ei)) check_eq("irdata", o_instr_rdata, ei);
    end
    if (o_data_ack && dq.size() > 0) begin
      e = dq.pop_front();
      check_eq("derr", o_data_err, e.err);
      if (!$isunknown(e.rdata)) check_eq("drdata", o_data_rdata, e.rdata);
    end
  end

  // Drive one cycle of stimulus, push expectations, advance to just after the edge.
  task automatic step(input logic ireq, input logic [7:0] iaddr, input logic dreq,
                      input logic dwe, input logic [3:0] be, input logic [7:0] daddr,
                      input logic [31:0] wd, input logic kstb, input logic [15:0] kin);
    exp_t        e;
    logic [31:0] ie;
    logic        d_in;
    i_instr_req = ireq; i_instr_addr = iaddr;
    i_data_req = dreq; i_data_we = dwe; i_data_be = be; i_data_addr = daddr;
    i_data_wdata = wd; i_kbd_strobe = kstb; i_keyboard_in = kin;
    d_in = (int'(daddr) < c_DEPTH);
    if (dreq) begin
      e.err   = !d_in && (int'(daddr) != c_KBD);
      e.rdata = (int'(daddr) == c_KBD) ? kbd_word() : (d_in ? m_mem[daddr] : 32'h0);
      dq.push_back(e);
      if (dwe && d_in && int'(daddr) != c_KBD) begin
        m_mem[daddr] = merge(m_mem[daddr], wd, be);
        if (int'(daddr) >= c_LCD && int'(daddr) < c_LCD + 8)
          m_lcd[int'(daddr) - c_LCD] = merge(m_lcd[int'(daddr) - c_LCD], wd, be);
      end
    end
    if (ireq) begin
      if (int'(iaddr) == c_KBD)           ie = kbd_word();
      else if (int'(iaddr) >= c_DEPTH)    ie = 32'h0;
      else                                ie = m_mem[iaddr];
      iq.push_back(ie);
    end
    if (kstb) begin
      m_latch = kin;
      m_pend  = 1'b1;
    end else if (dreq && !dwe && int'(daddr) == c_KBD) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    i_instr_req = 1'b0; i_data_req = 1'b0; i_data_we = 1'b0; i_kbd_strobe = 1'b0;
  endtask

  task automatic dwrite(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(1'b0, 8'h0, 1'b1, 1'b1, be, a, wd, 1'b0, 16'h0);
  endtask

  task automatic dread(input logic [7:0] a);
    step(1'b0, 8'h0, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic iread(input logic [7:0] a);
    step(1'b1, a, 1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 16'h0);
  endtask

  task automatic reset_model();
    m_latch = '0;
    m_pend  = 1'b0;
    for (int i = 0; i < 8; i++) m_lcd[i] = '0;
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 17);
    if (r < 8)   return 8'(r);
    if (r == 8)  return 8'd16;
    if (r == 9)  return 8'(c_KBD);
    return 8'(c_LCD + r - 10);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 'x;
    reset_model();
    #1;
    check_eq("rst_iack", o_instr_ack, 1'b0);
    check_eq("rst_dack", o_data_ack, 1'b0);
    check_eq("rst_drdata", o_data_rdata, 32'h0);
    check_eq("rst_lcd", |o_lcd_data_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int a = 0; a < 16; a++) dwrite(8'(a), 32'hC0DE_0000 + 32'(a) * 32'h0101, 4'hF);
    iread(8'd3);
    check_eq("t1_ack", o_instr_ack, 1'b1);
    check_eq("t1_rdata", o_instr_rdata, 32'hC0DE_0303);

    dwrite(8'h10, 32'h1122_3344, 4'b1111);
    dwrite(8'h10, 32'hAABB_CCDD, 4'b0101);
    dread(8'h10);
    check_eq("t2_merge", o_data_rdata, 32'h11BB_33DD);
    dwrite(8'h10, 32'hFFFF_FFFF, 4'b0000);
    dread(8'h10);
    check_eq("be0_nowrite", o_data_rdata, 32'h11BB_33DD);

    dwrite(8'h20, 32'h0102_0304, 4'hF);
    step(1'b1, 8'h20, 1'b1, 1'b1, 4'hF, 8'h20, 32'hDEAD_BEEF, 1'b0, 16'h0);
    check_eq("t3_bypass", o_instr_rdata, 32'hDEAD_BEEF);
    check_eq("t3_old", o_data_rdata, 32'h0102_0304);

    step(1'b0, 8'h0, 1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 16'h00A5);
    dread(8'(c_KBD));
    check_eq("t4_pend", o_data_rdata, 32'h8000_00A5);
    dread(8'(c_KBD));
    check_eq("t4_clr", o_data_rdata, 32'h0000_00A5);
    step(1'b0, 8'h0, 1'b1, 1'b0, 4'h0, 8'(c_KBD), 32'h0, 1'b1, 16'h0042);
    check_eq("t4_race_old", o_data_rdata, 32'h0000_00A5);
    iread(8'(c_KBD));
    check_eq("t4_iread", o_instr_rdata, 32'h8000_0042);
    dwrite(8'(c_KBD), 32'hFFFF_FFFF, 4'hF);
    dread(8'(c_KBD));
    check_eq("t4_keep", o_data_rdata, 32'h8000_0042);
    dread(8'(c_KBD));

    dwrite(8'd45, 32'h1234_5678, 4'hF);
    check_eq("t5_upd", o_lcd_update, 1'b1);
    check_eq("t5_word", o_lcd_data_out[3*32 +: 32], 32'h1234_5678);
    lcd_mask = {224'h0, 32'hFFFF_FFFF} << 96;
    check_eq("t5_others", |(o_lcd_data_out & ~lcd_mask), 1'b0);
    idle();
    check_eq("t5_pulse", o_lcd_update, 1'b0);
    dwrite(8'd42, 32'hAABB_CCDD, 4'b0011);
    check_eq("lcd_be", o_lcd_data_out[31:0], 32'h0000_CCDD);
    dread(8'd45);

    dwrite(8'd210, 32'h5555_5555, 4'hF);
    dread(8'd210);
    check_eq("oor_err", o_data_err, 1'b1);
    check_eq("oor_rdata", o_data_rdata, 32'h0);
    iread(8'd210);
    check_eq("oor_instr", o_instr_rdata, 32'h0);

    for (int n = 0; n < 40; n++) begin
      a1 = pick_addr();
      a2 = pick_addr();
      step(1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom), a2, $urandom, ($urandom_range(0, 5) == 0), 16'($urandom));
      for (int i = 0; i < 8; i++)
        check_eq("lcd_shadow", o_lcd_data_out[i*32 +: 32], m_lcd[i]);
    end

    step(1'b0, 8'h0, 1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 16'h0077);
    dread(8'd10);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_dack", o_data_ack, 1'b0);
    check_eq("t6_drdata", o_data_rdata, 32'h0);
    check_eq("t6_lcd", |o_lcd_data_out, 1'b0);
    check_eq("t6_upd", o_lcd_update, 1'b0);
    iq.delete();
    dq.delete();
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dread(8'd10);
    check_eq("t6_mem", o_data_rdata, 32'hC0DE_0A0A);
    dread(8'(c_KBD));
    check_eq("t6_kbd", o_data_rdata, 32'h0);
    idle();
    idle();
    check_eq("iq_left", 64'(iq.size()), 64'd0);
    check_eq("dq_left", 64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
